risc_v_trace_buf: RTL

Instruction-trace capture buffer that sits directly downstream of the single-cycle `risc_v` core and consumes its debug port (`dbg_pc`, `dbg_instr`, `dbg_ALU_result`, `dbg_wr_en`). After being armed, it waits for an optional PC-match trigger. It then records a window of DEPTH consecutive retired-instruction samples into an internal FIFO. A first-word-fall-through valid/ready read port drains the FIFO toward a host or UART bridge.

---
 rtl/risc_v_trace_buf.sv | 88 ++++++++
 1 files changed

// File: rtl/risc_v_trace_buf.sv
// risc_v_trace_buf: armed, optionally PC-triggered capture of a DEPTH-sample
// debug window from the risc_v core into a first-word-fall-through FIFO.
module risc_v_trace_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [31:0]   dbg_pc,
    input  logic [31:0]   dbg_instr,
    input  logic [31:0]   dbg_ALU_result,
    input  logic          dbg_wr_en,
    input  logic          arm,
    input  logic          trig_en,
    input  logic [31:0]   trig_pc,
    input  logic          rd_ready,
    output logic          rd_valid,
    output logic [31:0]   rd_pc,
    output logic [31:0]   rd_instr,
    output logic [31:0]   rd_result,
    output logic          rd_wr_en,
    output logic [1:0]    state,
    output logic [AW:0]   count,
    output logic          triggered,
    output logic          overflow
);
    typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;

    state_t        state_q;
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q, count_d, cap_cnt_q;
    logic          triggered_q, overflow_q;
    logic [96:0]   mem_q [DEPTH];
    logic          fire, sample, push, pop;

    assign rd_valid = count_q != '0;
    assign pop      = rd_valid && rd_ready;
    assign fire     = state_q == ARMED && (!trig_en || dbg_pc == trig_pc);
    assign sample   = fire || state_q == CAPTURE;
    // A full FIFO still accepts a sample when the head leaves in the same cycle.
    assign push     = sample && (count_q != (AW+1)'(DEPTH) || pop);
    assign count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);

    assign {rd_pc, rd_instr, rd_result, rd_wr_en} = rd_valid ? mem_q[rptr_q] : '0;
    assign state     = state_q;
    assign count     = count_q;
    assign triggered = triggered_q;
    assign overflow  = overflow_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {dbg_pc, dbg_instr, dbg_ALU_result, dbg_wr_en};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            cap_cnt_q   <= '0;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (push) wptr_q <= wptr_q + 1'b1;
            if (pop) rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
            if (sample && !push) overflow_q <= 1'b1;
            case (state_q)
                IDLE, DONE: if (arm) begin
                    state_q     <= ARMED;
                    triggered_q <= 1'b0;
                    overflow_q  <= 1'b0;
                    cap_cnt_q   <= '0;
                end
                ARMED: if (fire) begin
                    state_q     <= CAPTURE;
                    triggered_q <= 1'b1;
                    cap_cnt_q   <= (AW+1)'(1);
                end
                CAPTURE: begin
                    cap_cnt_q <= cap_cnt_q + 1'b1;
                    if (cap_cnt_q == (AW+1)'(DEPTH-1)) state_q <= DONE;
                end
                default: ;
            endcase
        end
    end
endmodule
